// File: rtl/sharp_frame_scheduler.sv
// Line/mode sequencer for the LS013B7DH01 Sharp memory LCD: arbitrates all-clear,
// full-frame and VCOM maintenance jobs and hands line commands to the SPI writer.
module sharp_frame_scheduler #(
  parameter int unsigned LINES    = 168,
  parameter int unsigned VCOM_DIV = 6_000_000
) (
  input  logic       clk_12mhz,
  input  logic       rst_n,
  input  logic       frame_req,
  input  logic       clear_req,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_mode,
  output logic [7:0] cmd_addr,
  input  logic       line_done,
  output logic       busy,
  output logic       frame_done,
  output logic       vcom
);

  localparam int unsigned CntW = (VCOM_DIV > 1) ? $clog2(VCOM_DIV) : 1;
  localparam logic [CntW-1:0] VcomLast = CntW'(VCOM_DIV - 1);
  localparam logic [7:0] LastLine = 8'(LINES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic [1:0] {JobClear, JobFrame, JobVcom} job_e;

  state_e          state_q, state_d;
  job_e            job_q, job_d;
  logic [7:0]      line_q, line_d;
  logic [2:0]      mode_q, mode_d;
  logic [7:0]      addr_q, addr_d;
  logic            frame_done_q, frame_done_d;
  logic            vcom_q;
  logic [CntW-1:0] vcom_cnt_q;
  logic            clear_pend_q, frame_pend_q, vcom_pend_q;
  logic            clear_clr, frame_clr, vcom_clr;
  logic            vcom_tc;

  assign vcom_tc = (vcom_cnt_q == VcomLast);

  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    line_d       = line_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    clear_clr    = 1'b0;
    frame_clr    = 1'b0;
    vcom_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_pend_q) begin
          job_d     = JobClear;
          mode_d    = {1'b1, vcom_q, 1'b0};
          addr_d    = 8'd0;
          clear_clr = 1'b1;
          state_d   = StIssue;
        end else if (frame_pend_q) begin
          job_d     = JobFrame;
          line_d    = 8'd1;
          mode_d    = {1'b0, vcom_q, 1'b1};
          addr_d    = 8'd1;
          frame_clr = 1'b1;
          state_d   = StIssue;
        end else if (vcom_pend_q) begin
          job_d   = JobVcom;
          mode_d  = {1'b0, vcom_q, 1'b0};
          addr_d  = 8'd0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Every command carries the VCOM bit, so acceptance satisfies maintenance.
        if (cmd_ready) begin
          vcom_clr = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (line_done) begin
          if (job_q == JobFrame && line_q < LastLine) begin
            line_d  = line_q + 8'd1;
            mode_d  = {1'b0, vcom_q, 1'b1};
            addr_d  = line_q + 8'd1;
            state_d = StIssue;
          end else begin
            frame_done_d = (job_q == JobFrame);
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      job_q        <= JobClear;
      line_q       <= 8'd0;
      mode_q       <= 3'd0;
      addr_q       <= 8'd0;
      frame_done_q <= 1'b0;
      vcom_q       <= 1'b0;
      vcom_cnt_q   <= '0;
      clear_pend_q <= 1'b0;
      frame_pend_q <= 1'b0;
      vcom_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      line_q       <= line_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      vcom_q       <= vcom_q ^ vcom_tc;
      vcom_cnt_q   <= vcom_tc ? '0 : vcom_cnt_q + 1'b1;
      // A new request in the same cycle as the clear keeps the job pending.
      clear_pend_q <= clear_req | (clear_pend_q & ~clear_clr);
      frame_pend_q <= frame_req | (frame_pend_q & ~frame_clr);
      vcom_pend_q  <= vcom_tc | (vcom_pend_q & ~vcom_clr);
    end
  end

  assign cmd_valid  = (state_q == StIssue);
  assign busy       = (state_q != StIdle);
  assign cmd_mode   = mode_q;
  assign cmd_addr   = addr_q;
  assign frame_done = frame_done_q;
  assign vcom       = vcom_q;

endmodule

// File: tb/tb_sharp_frame_scheduler.sv
// Bench for sharp_frame_scheduler: job-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sharp_frame_scheduler;

  localparam int unsigned LINES = 4;
  localparam int unsigned VDIV  = 64;

  logic       clk_12mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_req = 1'b0;
  logic       clear_req = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       line_done = 1'b0;
  logic       cmd_valid, busy, frame_done, vcom;
  logic [2:0] cmd_mode;
  logic [7:0] cmd_addr;

  sharp_frame_scheduler #(.LINES(LINES), .VCOM_DIV(VDIV)) dut (
    .clk_12mhz (clk_12mhz),
    .rst_n     (rst_n),
    .frame_req (frame_req),
    .clear_req (clear_req),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_addr  (cmd_addr),
    .line_done (line_done),
    .busy      (busy),
    .frame_done(frame_done),
    .vcom      (vcom)
  );

  initial forever #5 clk_12mhz = ~clk_12mhz;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: job pending bits, the job in progress and whether its
  // command is still being offered; vcom follows directly from the edge count.
  int         m_edges;
  bit         m_pc, m_pf, m_pv, m_pres, m_fd;
  int         m_job;  // 0 none, 1 clear, 2 frame, 3 maintain
  int         m_line;
  logic [2:0] m_mode;
  logic [7:0] m_addr;

  function automatic bit m_vcom();
    return ((m_edges / VDIV) % 2) == 1;
  endfunction

  task automatic m_reset();
    m_edges = 0; m_pc = 0; m_pf = 0; m_pv = 0; m_pres = 0; m_fd = 0;
    m_job = 0; m_line = 0; m_mode = 3'd0; m_addr = 8'd0;
  endtask

  task automatic m_step();
    bit v, tc;
    v  = m_vcom();
    tc = (m_edges % VDIV) == (VDIV - 1);
    m_edges++;
    m_fd = 0;
    if (m_job == 0) begin
      if (m_pc) begin
        m_job = 1; m_pc = 0; m_mode = {1'b1, v, 1'b0}; m_addr = 8'd0; m_pres = 1;
      end else if (m_pf) begin
        m_job = 2; m_pf = 0; m_line = 1; m_mode = {1'b0, v, 1'b1}; m_addr = 8'd1; m_pres = 1;
      end else if (m_pv) begin
        m_job = 3; m_mode = {1'b0, v, 1'b0}; m_addr = 8'd0; m_pres = 1;
      end
    end else if (m_pres) begin
      if (cmd_ready) begin
        m_pres = 0; m_pv = 0;
      end
    end else if (line_done) begin
      if (m_job == 2 && m_line < LINES) begin
        m_line++; m_mode = {1'b0, v, 1'b1}; m_addr = 8'(m_line); m_pres = 1;
      end else begin
        m_fd = (m_job == 2); m_job = 0;
      end
    end
    if (clear_req) m_pc = 1;
    if (frame_req) m_pf = 1;
    if (tc) m_pv = 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_12mhz or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Compare process: outputs are stable at the falling edge.
  initial forever begin
    @(negedge clk_12mhz);
    if (rst_n) begin
      chk("cmd_valid", cmd_valid, m_job != 0 && m_pres);
      chk("busy", busy, m_job != 0);
      chk("frame_done", frame_done, m_fd);
      chk("vcom", vcom, m_vcom());
      if (m_job != 0 && m_pres) begin
        chk("cmd_mode", cmd_mode, m_mode);
        chk("cmd_addr", cmd_addr, m_addr);
      end
    end
  end

  // Writer model and command log; runs after the main process drives inputs.
  logic [2:0] lg_mode[$];
  logic [7:0] lg_addr[$];
  int         fd_count = 0;
  bit         rand_mode = 0;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk_12mhz);
      #2;
      line_done = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) line_done = 1'b1;
        end else if (rand_mode && $urandom_range(0, 49) == 0) begin
          line_done = 1'b1;
        end
        if (cmd_valid && cmd_ready) begin
          cnt = rand_mode ? int'($urandom_range(2, 12)) : 10;
          lg_mode.push_back(cmd_mode);
          lg_addr.push_back(cmd_addr);
        end
        if (frame_done) fd_count++;
      end
    end
  end

  int fd0;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_12mhz);
      #1;
    end
  endtask

  task automatic do_reset();
    tick(1);
    rst_n = 1'b0; frame_req = 1'b0; clear_req = 1'b0; cmd_ready = 1'b1;
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_vcom", vcom, 0);
    chk("rst_mode", cmd_mode, 0);
    chk("rst_addr", cmd_addr, 0);
    tick(1);
    rst_n = 1'b1;
    lg_mode.delete();
    lg_addr.delete();
    fd0 = fd_count;
  endtask

  task automatic pulse_frame();
    frame_req = 1'b1;
    tick(1);
    frame_req = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int k;
    k = 0;
    while (fd_count < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("frame_done_timeout", fd_count >= target, 1);
  endtask

  // Frame-line commands in log order (maintain and clear entries dropped).
  function automatic int n_lines();
    int n;
    n = 0;
    foreach (lg_mode[i]) if (lg_mode[i][0]) n++;
    return n;
  endfunction

  function automatic int line_addr(input int idx);
    int n;
    n = 0;
    foreach (lg_mode[i]) begin
      if (lg_mode[i][0]) begin
        if (n == idx) return int'(lg_addr[i]);
        n++;
      end
    end
    return -1;
  endfunction

  initial begin
    int k;
    // Single frame, request latency pinned by literals.
    do_reset();
    tick(2);
    frame_req = 1'b1;
    tick(1);
    frame_req = 1'b0;
    chk("lat_valid_early", cmd_valid, 0);
    tick(1);
    chk("lat_valid", cmd_valid, 1);
    chk("lat_busy", busy, 1);
    chk("lat_addr", cmd_addr, 1);
    chk("lat_mode", cmd_mode, 3'b001);
    wait_fd(fd0 + 1, 200);
    tick(3);
    chk("f1_busy_after", busy, 0);
    chk("f1_lines", n_lines(), 4);
    for (int i = 0; i < 4; i++) chk("f1_addr", line_addr(i), i + 1);
    chk("f1_fd", fd_count - fd0, 1);

    // Clear and frame in the same cycle: clear first, then the frame.
    do_reset();
    tick(2);
    clear_req = 1'b1;
    frame_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    frame_req = 1'b0;
    wait_fd(fd0 + 1, 300);
    chk("cf_first_mode", lg_mode[0], 3'b100);
    chk("cf_first_addr", lg_addr[0], 0);
    chk("cf_lines", n_lines(), 4);

    // Three extra requests during a frame queue exactly one more frame.
    do_reset();
    tick(2);
    pulse_frame();
    tick(15);
    pulse_frame();
    tick(5);
    pulse_frame();
    tick(5);
    pulse_frame();
    wait_fd(fd0 + 2, 400);
    tick(40);
    chk("ff_fd", fd_count - fd0, 2);
    chk("ff_lines", n_lines(), 8);
    for (int i = 0; i < 8; i++) chk("ff_addr", line_addr(i), (i % 4) + 1);

    // Idle: one maintain command per VCOM toggle.
    do_reset();
    tick(110);
    chk("mt_vcom", vcom, 1);
    chk("mt_count", lg_mode.size(), 1);
    chk("mt_mode", lg_mode[0], 3'b010);
    chk("mt_addr", lg_addr[0], 0);
    tick(30);
    chk("mt_count2", lg_mode.size(), 2);
    chk("mt_mode2", lg_mode[1], 3'b000);

    // Command held across a VCOM toggle keeps its mode; accept clears maintenance.
    do_reset();
    cmd_ready = 1'b0;
    tick(57);
    pulse_frame();
    tick(2);
    chk("hold_mode_pre", cmd_mode, 3'b001);
    tick(5);
    chk("hold_vcom", vcom, 1);
    chk("hold_valid", cmd_valid, 1);
    chk("hold_mode_post", cmd_mode, 3'b001);
    cmd_ready = 1'b1;
    wait_fd(fd0 + 1, 300);
    tick(5);
    chk("hold_count", lg_mode.size(), 4);
    chk("hold_acc_mode", lg_mode[0], 3'b001);
    for (int i = 1; i < 4; i++) chk("hold_next_mode", lg_mode[i], 3'b011);

    // Reset while waiting on line 2.
    do_reset();
    tick(2);
    pulse_frame();
    k = 0;
    while (lg_mode.size() < 2 && k < 100) begin
      tick(1);
      k++;
    end
    chk("rw_reach_line2", lg_mode.size() >= 2, 1);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("rw_valid", cmd_valid, 0);
    chk("rw_busy", busy, 0);
    chk("rw_mode", cmd_mode, 0);
    chk("rw_addr", cmd_addr, 0);
    tick(3);
    rst_n = 1'b1;
    lg_mode.delete();
    lg_addr.delete();
    tick(50);
    chk("rw_no_cmds", lg_mode.size(), 0);
    chk("rw_idle", busy, 0);

    // Randomized traffic against the model.
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      frame_req = ($urandom_range(0, 39) == 0);
      clear_req = ($urandom_range(0, 79) == 0);
      cmd_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    rand_mode = 0;
    frame_req = 1'b0;
    clear_req = 1'b0;
    cmd_ready = 1'b1;
    tick(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sharp_frame_scheduler.md
# sharp_frame_scheduler

- Sequences complete display updates for the LS013B7DH01 (144x168) Sharp memory LCD.
- Sits between the host/framebuffer logic and the per-line SPI writer, which produces the mode, address, data and dummy phases of one transfer. This block only tells the writer which lines to send and with which mode bits.
- Arbitrates between three jobs: all-clear, full-frame update and periodic VCOM maintenance.
- Generates the VCOM polarity inversion required by the panel.

## Interface
Parameters:
- LINES, 168, number of gate lines; addresses issued are 1..LINES.
- VCOM_DIV, 6_000_000, clk_12mhz cycles between VCOM toggles (1 Hz VCOM period at default).

Ports:
- clk_12mhz  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_req  in  1  request one full-frame update; sampled every cycle.
- clear_req  in  1  request a panel all-clear; sampled every cycle.
- cmd_valid  out  1  a line command is presented to the writer.
- cmd_ready  in  1  writer accepts the command when cmd_valid && cmd_ready.
- cmd_mode  out  3  mode bits: bit0 = M0 (update), bit1 = M1 (VCOM), bit2 = M2 (all clear).
- cmd_addr  out  8  gate line address; 0 for clear and maintain commands.
- line_done  in  1  one-cycle pulse from the writer when the accepted transfer, including SCS hold, has finished.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last line of a frame completes.
- vcom  out  1  current VCOM polarity.

## Operation
Pending flags (clear_pend, frame_pend, vcom_pend):
- Each flag is set when its source fires: clear_req high, frame_req high, or the VCOM counter reaching terminal.
- Repeated requests collapse into one pending job.
- If a set and a clear of the same flag occur in the same cycle, set wins.

VCOM counter:
- Counts 0..VCOM_DIV-1 free-running and wraps to 0.
- At terminal count: vcom toggles and vcom_pend is set.

States: IDLE, ISSUE, WAIT.
- IDLE: picks a job with priority clear_pend > frame_pend > vcom_pend, then goes to ISSUE.
  - Clear job: cmd_mode = {1, vcom, 0}, cmd_addr = 0; clear_pend cleared.
  - Frame job: line counter = 1, cmd_mode = {0, vcom, 1}, cmd_addr = 1; frame_pend cleared.
  - Maintain job: cmd_mode = {0, vcom, 0}, cmd_addr = 0.
  - If nothing is pending, stays in IDLE.
- ISSUE:
  - cmd_valid = 1; cmd_mode and cmd_addr are registered and held stable until acceptance, even if vcom toggles meanwhile.
  - On acceptance: go to WAIT and clear vcom_pend, since every command carries the VCOM bit.
- WAIT:
  - line_done on a frame job with line counter < LINES: increment the counter, reload cmd_mode with the current vcom, cmd_addr = counter+1, go to ISSUE.
  - line_done on a frame job's last line, or on a clear or maintain job: go to IDLE. For a frame job, frame_done pulses.
- No preemption: a clear_req arriving mid-frame is served after the frame completes. A frame_req arriving mid-frame queues exactly one further frame.
- line_done in IDLE or ISSUE is ignored.

## Timing
- Reset (async, immediate): cmd_valid=0, cmd_mode=0, cmd_addr=0, busy=0, frame_done=0, vcom=0; all pending flags, line counter and VCOM counter = 0; state = IDLE.
- Reset mid-transfer drops cmd_valid immediately. Pending jobs are discarded.
- Request latency: request sampled at edge k sets its pend flag at edge k; IDLE leaves at edge k+1. cmd_valid and busy are high from edge k+1.
- Line-to-line: line_done sampled at edge j gives cmd_valid high from edge j, i.e. one cycle after the pulse is seen.
- frame_done is high for exactly the one cycle following the edge that sampled the final line_done. busy falls at the same edge.
- A VCOM toggle while cmd_valid is held does not alter the presented cmd_mode. The next issued command uses the new vcom.
- Throughput: a frame takes LINES handshakes. The scheduler adds 1 idle cycle per line beyond the writer's time.

## Test plan
- Bench parameters LINES=4, VCOM_DIV=64, cmd_ready tied 1, writer model returns line_done 10 cycles after accept. One-cycle frame_req -> commands addr 1,2,3,4, each with cmd_mode=3'b001|vcom<<1; a single frame_done after addr 4's line_done; busy low afterward.
- clear_req and frame_req asserted in the same cycle -> first command addr 0 mode 3'b100, then frame lines 1..4.
- frame_req pulsed 3 times during a frame -> exactly one additional frame (8 line commands total, 2 frame_done pulses).
- Idle for 64 cycles -> vcom toggles to 1 and one maintain command is issued (addr 0, mode 3'b010). No further command until the next toggle.
- cmd_ready held 0 across a VCOM toggle -> cmd_mode unchanged until accept; vcom_pend cleared on accept.
- rst_n asserted while in WAIT of line 2 -> all outputs 0 immediately; no commands after release until a new request arrives.
